// File: rtl/shift_register_piso_tx_pkg.sv
// Shared types and helpers for the PISO transmitter and its bit counter.
package shift_register_piso_tx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic IDLE_LEVEL_DEF = 1'b0;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/shift_register_piso_tx_bit_counter.sv
// Frame bit counter: clears on word acceptance, counts enabled shifts, saturates at WIDTH-1.
module piso_bit_counter
  import shift_register_piso_tx_pkg::*;
#(
  parameter int  WIDTH = 4,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o  = (cnt_q == LAST);
  assign cnt_o = cnt_q;

endmodule

// File: rtl/shift_register_piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and Shift_EN pacing.
module shift_register_piso_tx
  import shift_register_piso_tx_pkg::*;
#(
  parameter int   WIDTH      = 4,
  parameter bit   LSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = IDLE_LEVEL_DEF,
  localparam int  CNT_W      = cnt_w(WIDTH)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] Data_IN,
  input  logic             Data_VALID,
  output logic             Data_READY,
  input  logic             Shift_EN,
  output logic             Serial_OUT,
  output logic             Frame_ACTIVE,
  output logic             Done,
  output logic [CNT_W-1:0] Bit_CNT
);

  localparam int OUT_IDX = LSB_FIRST ? 0 : WIDTH - 1;

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic             rdy_q;
  logic             done_q;
  logic             accept;
  logic             step;
  logic             last;

  assign accept = (state_q == IDLE) && Data_VALID && rdy_q;
  assign step   = (state_q == SHIFT) && Shift_EN;

  piso_bit_counter #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk_i  (CLK),
    .rst_ni (RST_N),
    .clr_i  (accept),
    .en_i   (step),
    .cnt_o  (Bit_CNT),
    .tc_o   (last)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (step && last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Frame_ACTIVE = (state_q == SHIFT);
    Serial_OUT   = (state_q == SHIFT) ? shreg_q[OUT_IDX] : IDLE_LEVEL;
  end

  // The register moves toward the output end; the final enabled edge leaves it untouched.
  always_comb begin
    shreg_d = shreg_q;
    if (accept) begin
      shreg_d = Data_IN;
    end else if (step && !last) begin
      shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  // Ready is registered so it stays low through reset and rises on the first edge after release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rdy_q  <= (state_d == IDLE);
      done_q <= step && last;
    end
  end

  assign Data_READY = rdy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_shift_register_piso_tx.sv
// Directed bench: LSB-first and MSB-first transmitters side by side, plus a 4-bit SISO receiver model.
module tb_shift_register_piso_tx;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] Data_IN;
  logic       Data_VALID;
  logic       Shift_EN;

  logic       rdy_l, ser_l, fa_l, done_l;
  logic [1:0] cnt_l;
  logic       rdy_m, ser_m, fa_m, done_m;
  logic [1:0] cnt_m;
  logic [3:0] rx_q;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  shift_register_piso_tx #(
    .WIDTH      (4),
    .LSB_FIRST  (1'b1),
    .IDLE_LEVEL (1'b0)
  ) u_lsb (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .Data_IN      (Data_IN),
    .Data_VALID   (Data_VALID),
    .Data_READY   (rdy_l),
    .Shift_EN     (Shift_EN),
    .Serial_OUT   (ser_l),
    .Frame_ACTIVE (fa_l),
    .Done         (done_l),
    .Bit_CNT      (cnt_l)
  );

  shift_register_piso_tx #(
    .WIDTH      (4),
    .LSB_FIRST  (1'b0),
    .IDLE_LEVEL (1'b0)
  ) u_msb (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .Data_IN      (Data_IN),
    .Data_VALID   (Data_VALID),
    .Data_READY   (rdy_m),
    .Shift_EN     (Shift_EN),
    .Serial_OUT   (ser_m),
    .Frame_ACTIVE (fa_m),
    .Done         (done_m),
    .Bit_CNT      (cnt_m)
  );

  // Receiver: Load = Frame_ACTIVE & Shift_EN, shifting toward q[0].
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_q <= '0;
    end else if (fa_l && Shift_EN) begin
      rx_q <= {ser_l, rx_q[3:1]};
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sends one word from IDLE; alt=1 holds every bit for two cycles.
  task automatic frame(input logic [3:0] w, input logic alt);
    int n;
    int k;
    Data_IN    = w;
    Data_VALID = 1'b1;
    Shift_EN   = 1'b1;
    @(negedge CLK);
    Data_VALID = 1'b0;
    n = 0;
    while (fa_l && n < 20) begin
      k = alt ? n / 2 : n;
      check("lsb_bit", ser_l, w[k]);
      check("msb_bit", ser_m, w[3-k]);
      check("bit_cnt", cnt_l, k);
      check("msb_cnt", cnt_m, k);
      check("no_early_done", done_l, 0);
      check("busy_rdy", rdy_l, 0);
      Shift_EN = alt ? n[0] : 1'b1;
      @(negedge CLK);
      n++;
    end
    check("frame_len", n, alt ? 8 : 4);
    check("done", done_l, 1);
    check("done_msb", done_m, 1);
    check("rdy_after", rdy_l, 1);
    check("rx_q", rx_q, w);
    @(negedge CLK);
    check("done_pulse", done_l, 0);
    check("idle_ser", ser_l, 0);
    Shift_EN = 1'b1;
  endtask

  initial begin
    logic [3:0] wd;
    RST_N      = 1'b0;
    Data_IN    = '0;
    Data_VALID = 1'b0;
    Shift_EN   = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_ser", ser_l, 0);
    check("rst_fa", fa_l, 0);
    check("rst_rdy", rdy_l, 0);
    check("rst_done", done_l, 0);
    check("rst_cnt", cnt_l, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("rdy_rise", rdy_l, 1);
    check("rdy_rise_msb", rdy_m, 1);

    frame(4'b1011, 1'b0);
    frame(4'b1011, 1'b1);

    // Back-to-back requests with Data_VALID held high; Data_IN disturbed mid-frame.
    Data_IN    = 4'h6;
    Data_VALID = 1'b1;
    Shift_EN   = 1'b1;
    @(negedge CLK);
    for (int f = 0; f < 2; f++) begin
      wd = (f == 0) ? 4'h6 : 4'h9;
      for (int i = 0; i < 4; i++) begin
        check("b2b_fa", fa_l, 1);
        check("b2b_lsb", ser_l, wd[i]);
        check("b2b_msb", ser_m, wd[3-i]);
        if (f == 0 && i == 1) Data_IN = 4'hF;
        if (f == 0 && i == 3) Data_IN = 4'h9;
        if (f == 1 && i == 0) Data_VALID = 1'b0;
        @(negedge CLK);
      end
      check("b2b_gap_fa", fa_l, 0);
      check("b2b_gap_ser", ser_l, 0);
      check("b2b_done", done_l, 1);
      check("b2b_rx", rx_q, wd);
      @(negedge CLK);
    end
    check("b2b_end_fa", fa_l, 0);
    check("b2b_end_done", done_l, 0);

    // Abort a frame of 4'hC after two bits with an asynchronous reset.
    Data_IN    = 4'hC;
    Data_VALID = 1'b1;
    @(negedge CLK);
    Data_VALID = 1'b0;
    check("abort_b0", ser_l, 0);
    @(negedge CLK);
    check("abort_b1", ser_l, 0);
    @(negedge CLK);
    check("abort_b2", ser_l, 1);
    #1 RST_N = 1'b0;
    #1;
    check("abort_fa", fa_l, 0);
    check("abort_rdy", rdy_l, 0);
    check("abort_ser", ser_l, 0);
    check("abort_cnt", cnt_l, 0);
    check("abort_done", done_l, 0);
    @(negedge CLK);
    check("abort_hold_done", done_l, 0);
    check("abort_hold_rdy", rdy_l, 0);
    RST_N = 1'b1;
    @(negedge CLK);
    check("abort_rdy_rise", rdy_l, 1);
    check("abort_no_done", done_l, 0);

    frame(4'h5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1);
  end

endmodule
